// File: rtl/lockstep_divergence_monitor_if.sv
// Observation bundle for the lockstep monitor: per-lane ROB enqueue and commit
// streams from the DUT and the variant core. Lane i instruction sits at [i*INST_W +: INST_W].
interface lockstep_divergence_monitor_if #(
  parameter int LANES  = 2,
  parameter int INST_W = 32
);
  logic [LANES-1:0]        dut_enq_valid;
  logic [LANES*INST_W-1:0] dut_enq_inst;
  logic [LANES-1:0]        vnt_enq_valid;
  logic [LANES*INST_W-1:0] vnt_enq_inst;
  logic [LANES-1:0]        dut_deq_valid;
  logic [LANES*INST_W-1:0] dut_deq_inst;
  logic [LANES-1:0]        vnt_deq_valid;
  logic [LANES*INST_W-1:0] vnt_deq_inst;

  // Harness side drives the streams.
  modport master (
    output dut_enq_valid, dut_enq_inst, vnt_enq_valid, vnt_enq_inst,
    output dut_deq_valid, dut_deq_inst, vnt_deq_valid, vnt_deq_inst
  );

  // Monitor side only observes.
  modport slave (
    input dut_enq_valid, dut_enq_inst, vnt_enq_valid, vnt_enq_inst,
    input dut_deq_valid, dut_deq_inst, vnt_deq_valid, vnt_deq_inst
  );
endinterface

// File: rtl/lockstep_divergence_monitor.sv
// Multi-lane lockstep comparator: latches the first DUT/variant enqueue divergence,
// then tracks both sides reaching the end-of-test marker, with an optional timeout.
module lockstep_divergence_monitor #(
  parameter int                 LANES     = 2,
  parameter int                 INST_W    = 32,
  parameter logic [INST_W-1:0]  DONE_INST = INST_W'(32'h00302013),
  parameter int                 TIMEOUT   = 4096,
  parameter int                 CNT_W     = 32,
  localparam int                LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  lockstep_divergence_monitor_if.slave mon,
  output logic                         in_sync,
  output logic [CNT_W-1:0]             div_cycle,
  output logic [LANE_W-1:0]            div_lane,
  output logic                         dut_done,
  output logic                         vnt_done,
  output logic                         finished,
  output logic                         timed_out,
  output logic [2:0]                   state
);

  // Handshake: a valid bit qualifies its lane's instruction in that same cycle;
  // there is no ready, the monitor never backpressures either stream.
  typedef enum logic [2:0] {
    S_SYNC       = 3'd0,
    S_DIVERGED   = 3'd1,
    S_WAIT_OTHER = 3'd2,
    S_FINISHED   = 3'd3,
    S_TIMEOUT    = 3'd4
  } state_t;

  localparam bit               TO_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cycle_cnt;
  logic [CNT_W-1:0]    to_cnt;
  logic [LANES-1:0]    lane_mm;
  logic                any_mm;
  logic [LANE_W-1:0]   first_mm;
  logic                dut_hit, vnt_hit;
  logic                tracking;
  logic                to_expire;

  always_comb begin
    lane_mm  = '0;
    first_mm = '0;
    dut_hit  = 1'b0;
    vnt_hit  = 1'b0;
    // Descending scan so the lowest mismatching lane is the last one written.
    for (int i = LANES - 1; i >= 0; i--) begin
      lane_mm[i] = (mon.dut_enq_valid[i] != mon.vnt_enq_valid[i]) ||
                   (mon.dut_enq_valid[i] &&
                    (mon.dut_enq_inst[i*INST_W +: INST_W] != mon.vnt_enq_inst[i*INST_W +: INST_W]));
      if (lane_mm[i]) first_mm = LANE_W'(i);
      if (mon.dut_deq_valid[i] && (mon.dut_deq_inst[i*INST_W +: INST_W] == DONE_INST)) dut_hit = 1'b1;
      if (mon.vnt_deq_valid[i] && (mon.vnt_deq_inst[i*INST_W +: INST_W] == DONE_INST)) vnt_hit = 1'b1;
    end
  end

  assign any_mm   = |lane_mm;
  assign tracking = (state_q == S_DIVERGED) || (state_q == S_WAIT_OTHER);

  // Transitions look at the registered done flags, so completion shows one cycle after the flag.
  always_comb begin
    state_d   = state_q;
    to_expire = TO_EN && (to_cnt == TO_LAST);
    unique case (state_q)
      S_SYNC: begin
        if (any_mm) state_d = S_DIVERGED;
      end
      S_DIVERGED: begin
        if (dut_done && vnt_done)      state_d = S_FINISHED;
        else if (to_expire)            state_d = S_TIMEOUT;
        else if (dut_done || vnt_done) state_d = S_WAIT_OTHER;
      end
      S_WAIT_OTHER: begin
        if (dut_done && vnt_done) state_d = S_FINISHED;
        else if (to_expire)       state_d = S_TIMEOUT;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_SYNC;
      cycle_cnt <= '0;
      to_cnt    <= '0;
      div_cycle <= '0;
      div_lane  <= '0;
      dut_done  <= 1'b0;
      vnt_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if ((state_q == S_SYNC) && any_mm) begin
        div_cycle <= cycle_cnt;
        div_lane  <= first_mm;
        to_cnt    <= '0;
      end
      if (tracking) begin
        if (dut_hit) dut_done <= 1'b1;
        if (vnt_hit) vnt_done <= 1'b1;
        if (TO_EN)   to_cnt   <= to_cnt + CNT_W'(1);
      end
    end
  end

  assign in_sync   = (state_q == S_SYNC);
  assign finished  = (state_q == S_FINISHED);
  assign timed_out = (state_q == S_TIMEOUT);
  assign state     = state_q;

endmodule

// File: tb/tb_lockstep_divergence_monitor.sv
// Bench for lockstep_divergence_monitor: a default instance and a TIMEOUT=16 instance
// share one stimulus bus; table vectors, directed sequences and a random episode model.
module tb_lockstep_divergence_monitor;

  localparam logic [31:0] DONE = 32'h00302013;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lockstep_divergence_monitor_if #(.LANES(2), .INST_W(32)) bus ();

  logic        a_in_sync, a_dut_done, a_vnt_done, a_finished, a_timed_out;
  logic [31:0] a_div_cycle;
  logic [0:0]  a_div_lane;
  logic [2:0]  a_state;
  logic        b_in_sync, b_dut_done, b_vnt_done, b_finished, b_timed_out;
  logic [31:0] b_div_cycle;
  logic [0:0]  b_div_lane;
  logic [2:0]  b_state;

  lockstep_divergence_monitor u_dut (
    .clock(clock), .reset(reset), .mon(bus),
    .in_sync(a_in_sync), .div_cycle(a_div_cycle), .div_lane(a_div_lane),
    .dut_done(a_dut_done), .vnt_done(a_vnt_done), .finished(a_finished),
    .timed_out(a_timed_out), .state(a_state)
  );

  lockstep_divergence_monitor #(.TIMEOUT(16)) u_dut_to (
    .clock(clock), .reset(reset), .mon(bus),
    .in_sync(b_in_sync), .div_cycle(b_div_cycle), .div_lane(b_div_lane),
    .dut_done(b_dut_done), .vnt_done(b_vnt_done), .finished(b_finished),
    .timed_out(b_timed_out), .state(b_state)
  );

  // Stimulus variables, packed onto the bus by step().
  logic [1:0]  dev, vev, ddv, vdv;
  logic [31:0] dei [2];
  logic [31:0] vei [2];
  logic [31:0] ddi [2];
  logic [31:0] vdi [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Per-sample event history since the last reset, indexed by cycle-counter value.
  bit mm_q[$];
  int ml_q[$];
  bit dh_q[$];
  bit vh_q[$];

  typedef struct {
    bit in_sync;
    int div_cycle;
    int div_lane;
    bit dd;
    bit vd;
    bit fin;
    bit tmo;
    int st;
  } exp_t;

  typedef struct {
    logic [1:0]  dev;
    logic [1:0]  vev;
    logic [31:0] de0, de1, ve0, ve1;
    logic [1:0]  ddv;
    logic [1:0]  vdv;
    bit          exp_sync;
    int          exp_lane;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    dev = '0; vev = '0; ddv = '0; vdv = '0;
    for (int i = 0; i < 2; i++) begin
      dei[i] = 32'h13; vei[i] = 32'h13; ddi[i] = 32'h13; vdi[i] = 32'h13;
    end
  endtask

  function automatic logic [31:0] pick_inst();
    case ($urandom_range(0, 2))
      0:       return 32'h00000013;
      1:       return DONE;
      default: return $urandom;
    endcase
  endfunction

  // Identical enqueue streams; commits may carry the done marker on either side.
  task automatic set_identical(input bit with_done);
    for (int i = 0; i < 2; i++) begin
      dev[i] = ($urandom_range(0, 3) != 0);
      vev[i] = dev[i];
      dei[i] = pick_inst();
      vei[i] = dev[i] ? dei[i] : pick_inst();
      ddv[i] = $urandom_range(0, 1);
      vdv[i] = $urandom_range(0, 1);
      ddi[i] = (with_done && $urandom_range(0, 3) == 0) ? DONE : 32'h00000013;
      vdi[i] = (with_done && $urandom_range(0, 3) == 0) ? DONE : 32'h00000013;
    end
  endtask

  task automatic set_random(input int mm_den);
    for (int i = 0; i < 2; i++) begin
      dev[i] = ($urandom_range(0, 3) != 0);
      vev[i] = dev[i];
      dei[i] = pick_inst();
      vei[i] = dev[i] ? dei[i] : pick_inst();
      if ($urandom_range(0, mm_den - 1) == 0) begin
        if ($urandom_range(0, 1) == 1) vev[i] = ~vev[i];
        else                            vei[i] = dei[i] ^ 32'h00100000;
      end
      ddv[i] = $urandom_range(0, 1);
      vdv[i] = $urandom_range(0, 1);
      ddi[i] = ($urandom_range(0, 9) == 0) ? DONE : pick_inst();
      vdi[i] = ($urandom_range(0, 9) == 0) ? DONE : pick_inst();
    end
  endtask

  // Drive the bus, log the sample's events, clock once, then settle past the edge.
  task automatic step();
    bit mm;
    int ml;
    bus.dut_enq_valid = dev;
    bus.vnt_enq_valid = vev;
    bus.dut_deq_valid = ddv;
    bus.vnt_deq_valid = vdv;
    bus.dut_enq_inst  = {dei[1], dei[0]};
    bus.vnt_enq_inst  = {vei[1], vei[0]};
    bus.dut_deq_inst  = {ddi[1], ddi[0]};
    bus.vnt_deq_inst  = {vdi[1], vdi[0]};
    if (reset) begin
      mm = 1'b0;
      ml = 0;
      for (int i = 1; i >= 0; i--) begin
        if ((dev[i] != vev[i]) || (dev[i] && (dei[i] != vei[i]))) begin
          mm = 1'b1;
          ml = i;
        end
      end
      mm_q.push_back(mm);
      ml_q.push_back(ml);
      dh_q.push_back((ddv[0] && ddi[0] == DONE) || (ddv[1] && ddi[1] == DONE));
      vh_q.push_back((vdv[0] && vdi[0] == DONE) || (vdv[1] && vdi[1] == DONE));
    end
    @(posedge clock);
    #1;
    if (reset) cyc++;
    else begin
      cyc = 0;
      mm_q.delete(); ml_q.delete(); dh_q.delete(); vh_q.delete();
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    set_idle();
    step();
    reset = 1'b1;
  endtask

  // Expected outputs after the latest recorded sample, from event times:
  // divergence D, first post-divergence done commits, completion at max+1, expiry at D+tlen.
  function automatic exp_t model(input int tlen);
    exp_t e;
    int s, d, dd, vd, t_exp, f_at;
    e = '{in_sync: 1'b1, div_cycle: 0, div_lane: 0, dd: 1'b0, vd: 1'b0, fin: 1'b0, tmo: 1'b0, st: 0};
    s = mm_q.size() - 1;
    d = -1;
    for (int t = 0; t <= s; t++) begin
      if (mm_q[t]) begin
        d = t;
        e.div_lane = ml_q[t];
        break;
      end
    end
    if (d < 0) return e;
    e.in_sync   = 1'b0;
    e.div_cycle = d;
    dd = -1;
    vd = -1;
    for (int t = d + 1; t <= s; t++) begin
      if (dh_q[t] && dd < 0) dd = t;
      if (vh_q[t] && vd < 0) vd = t;
    end
    t_exp = (tlen > 0) ? d + tlen : 32'h3fffffff;
    f_at  = (dd >= 0 && vd >= 0) ? ((dd > vd ? dd : vd) + 1) : 32'h3fffffff;
    if (f_at <= t_exp) begin
      e.fin = (f_at <= s);
    end else begin
      e.tmo = (t_exp <= s);
      if (dd > t_exp) dd = -1;
      if (vd > t_exp) vd = -1;
    end
    e.dd = (dd >= 0);
    e.vd = (vd >= 0);
    if (e.fin)      e.st = 3;
    else if (e.tmo) e.st = 4;
    else if ((dd >= 0 && dd <= s - 1) || (vd >= 0 && vd <= s - 1)) e.st = 2;
    else            e.st = 1;
    return e;
  endfunction

  task automatic check_model();
    exp_t ea, eb;
    ea = model(4096);
    eb = model(16);
    chk("rnd_a_in_sync",   a_in_sync,   ea.in_sync);
    chk("rnd_a_state",     a_state,     ea.st);
    chk("rnd_a_div_cycle", a_div_cycle, ea.div_cycle);
    chk("rnd_a_div_lane",  a_div_lane,  ea.div_lane);
    chk("rnd_a_dut_done",  a_dut_done,  ea.dd);
    chk("rnd_a_vnt_done",  a_vnt_done,  ea.vd);
    chk("rnd_a_finished",  a_finished,  ea.fin);
    chk("rnd_a_timed_out", a_timed_out, ea.tmo);
    chk("rnd_b_in_sync",   b_in_sync,   eb.in_sync);
    chk("rnd_b_state",     b_state,     eb.st);
    chk("rnd_b_div_cycle", b_div_cycle, eb.div_cycle);
    chk("rnd_b_div_lane",  b_div_lane,  eb.div_lane);
    chk("rnd_b_dut_done",  b_dut_done,  eb.dd);
    chk("rnd_b_vnt_done",  b_vnt_done,  eb.vd);
    chk("rnd_b_finished",  b_finished,  eb.fin);
    chk("rnd_b_timed_out", b_timed_out, eb.tmo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [8];
    vecs[0] = '{2'b11, 2'b11, 32'h13, 32'h93, 32'h13, 32'h93, 2'b00, 2'b00, 1'b1, 0};
    vecs[1] = '{2'b00, 2'b00, 32'h13, 32'h93, 32'hAA, 32'hBB, 2'b11, 2'b11, 1'b1, 0};
    vecs[2] = '{2'b01, 2'b00, 32'h13, 32'h13, 32'h13, 32'h13, 2'b11, 2'b11, 1'b0, 0};
    vecs[3] = '{2'b10, 2'b00, 32'h13, 32'h13, 32'h13, 32'h13, 2'b00, 2'b00, 1'b0, 1};
    vecs[4] = '{2'b11, 2'b11, 32'h13, 32'h93, 32'h14, 32'h93, 2'b01, 2'b10, 1'b0, 0};
    vecs[5] = '{2'b11, 2'b11, 32'h13, 32'h93, 32'h14, 32'h94, 2'b00, 2'b00, 1'b0, 0};
    vecs[6] = '{2'b11, 2'b11, 32'h13, 32'h00000013, 32'h13, 32'h00100013, 2'b00, 2'b00, 1'b0, 1};
    vecs[7] = '{2'b10, 2'b10, 32'h13, 32'h93, 32'h55, 32'h93, 2'b11, 2'b11, 1'b1, 0};

    set_idle();
    repeat (2) step();
    reset = 1'b1;
    reset_dut();
    chk("reset_in_sync",   a_in_sync,   1'b1);
    chk("reset_state",     a_state,     3'd0);
    chk("reset_div_cycle", a_div_cycle, 32'd0);
    chk("reset_div_lane",  a_div_lane,  1'b0);
    chk("reset_flags",     {a_dut_done, a_vnt_done, a_finished, a_timed_out}, 4'b0000);

    // Table vectors: a single sample after reset, then one idle cycle.
    for (int v = 0; v < 8; v++) begin
      reset_dut();
      dev = vecs[v].dev; vev = vecs[v].vev;
      dei[0] = vecs[v].de0; dei[1] = vecs[v].de1;
      vei[0] = vecs[v].ve0; vei[1] = vecs[v].ve1;
      ddv = vecs[v].ddv; vdv = vecs[v].vdv;
      ddi[0] = DONE; ddi[1] = DONE; vdi[0] = DONE; vdi[1] = DONE;
      step();
      chk($sformatf("vec%0d_in_sync", v),   a_in_sync,   vecs[v].exp_sync);
      chk($sformatf("vec%0d_state", v),     a_state,     vecs[v].exp_sync ? 3'd0 : 3'd1);
      chk($sformatf("vec%0d_div_lane", v),  a_div_lane,  vecs[v].exp_lane);
      chk($sformatf("vec%0d_div_cycle", v), a_div_cycle, 32'd0);
      set_idle();
      step();
      chk($sformatf("vec%0d_dut_done", v), a_dut_done, 1'b0);
      chk($sformatf("vec%0d_vnt_done", v), a_vnt_done, 1'b0);
    end

    // Long identical run with marker commits: done tracking must stay off.
    reset_dut();
    for (int k = 0; k < 1000; k++) begin
      set_identical(1'b1);
      step();
      chk("sync_in_sync",  a_in_sync,  1'b1);
      chk("sync_dut_done", a_dut_done, 1'b0);
      chk("sync_finished", a_finished, 1'b0);
      chk("sync_b_vnt",    b_vnt_done, 1'b0);
    end

    // Divergence at counter 57 on lane 1, staggered completion, timeout on the 16-cycle instance.
    reset_dut();
    for (int s = 0; s < 57; s++) begin
      set_identical(1'b0);
      step();
    end
    chk("pre_div_in_sync", a_in_sync, 1'b1);
    set_idle();
    dev = 2'b11; vev = 2'b11;
    dei[1] = 32'h00000013; vei[1] = 32'h00100013;
    step();
    chk("div_in_sync",   a_in_sync,   1'b0);
    chk("div_state",     a_state,     3'd1);
    chk("div_cycle",     a_div_cycle, 32'd57);
    chk("div_lane",      a_div_lane,  1'b1);
    chk("div_b_state",   b_state,     3'd1);
    for (int s = 58; s <= 90; s++) begin
      set_idle();
      if (s == 60) begin dev = 2'b01; vev = 2'b00; end
      if (s == 67) begin ddv[0] = 1'b1; ddi[0] = DONE; end
      if (s == 82) begin vdv[1] = 1'b1; vdi[1] = DONE; end
      step();
      case (s)
        60: begin
          chk("latch_div_lane",  a_div_lane,  1'b1);
          chk("latch_div_cycle", a_div_cycle, 32'd57);
        end
        66: chk("pre_dut_done", a_dut_done, 1'b0);
        67: begin
          chk("dut_done_set",   a_dut_done, 1'b1);
          chk("dut_done_state", a_state,    3'd1);
        end
        68: chk("wait_other_state", a_state, 3'd2);
        72: begin
          chk("to_b_state_pre", b_state,     3'd2);
          chk("to_b_tmo_pre",   b_timed_out, 1'b0);
        end
        73: begin
          chk("to_b_state",    b_state,     3'd4);
          chk("to_b_timed_out", b_timed_out, 1'b1);
          chk("to_b_vnt_done", b_vnt_done,  1'b0);
          chk("to_a_state",    a_state,     3'd2);
        end
        81: chk("pre_vnt_done", a_vnt_done, 1'b0);
        82: begin
          chk("vnt_done_set",   a_vnt_done, 1'b1);
          chk("vnt_done_fin",   a_finished, 1'b0);
          chk("vnt_done_state", a_state,    3'd2);
        end
        83: begin
          chk("finished_set",   a_finished, 1'b1);
          chk("finished_state", a_state,    3'd3);
        end
        90: begin
          chk("hold_a_state",     a_state,     3'd3);
          chk("hold_a_div_cycle", a_div_cycle, 32'd57);
          chk("hold_b_state",     b_state,     3'd4);
          chk("hold_b_vnt_done",  b_vnt_done,  1'b0);
          chk("hold_b_dut_done",  b_dut_done,  1'b1);
        end
        default: ;
      endcase
    end

    // Both sides commit the marker together: straight to FINISHED.
    reset_dut();
    set_idle(); dev = 2'b10; step();
    set_idle(); step();
    set_idle(); ddv[1] = 1'b1; ddi[1] = DONE; vdv[0] = 1'b1; vdi[0] = DONE; step();
    chk("same_dut_done", a_dut_done, 1'b1);
    chk("same_vnt_done", a_vnt_done, 1'b1);
    chk("same_state",    a_state,    3'd1);
    set_idle(); step();
    chk("same_fin_state", a_state,    3'd3);
    chk("same_finished",  a_finished, 1'b1);

    // Reset while waiting on the other side.
    reset_dut();
    for (int s = 0; s <= 6; s++) begin
      set_idle();
      if (s == 3) begin dev = 2'b10; vev = 2'b10; dei[1] = 32'h1; vei[1] = 32'h2; end
      if (s == 5) begin ddv[0] = 1'b1; ddi[0] = DONE; end
      step();
    end
    chk("pre_rst_state", a_state, 3'd2);
    reset = 1'b0;
    set_idle(); dev = 2'b11; vev = 2'b00; ddv = 2'b11; vdv = 2'b11;
    ddi[0] = DONE; vdi[0] = DONE;
    step();
    reset = 1'b1;
    chk("mid_rst_state",     a_state,     3'd0);
    chk("mid_rst_in_sync",   a_in_sync,   1'b1);
    chk("mid_rst_div_cycle", a_div_cycle, 32'd0);
    chk("mid_rst_div_lane",  a_div_lane,  1'b0);
    chk("mid_rst_flags",     {a_dut_done, a_vnt_done, a_finished, a_timed_out}, 4'b0000);
    set_idle();
    step();
    chk("post_rst_in_sync", a_in_sync, 1'b1);

    // Randomized episodes against the event-time model.
    for (int ep = 0; ep < 20; ep++) begin
      int den;
      den = $urandom_range(8, 120);
      reset_dut();
      for (int k = 0; k < 80; k++) begin
        set_random(den);
        step();
        check_model();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lockstep_divergence_monitor.md
Name: lockstep_divergence_monitor

Overview:
- Multi-lane lockstep comparator for paired DUT/variant simulation harnesses.
- Compares per-lane ROB-enqueue streams of the DUT and the variant core every cycle, and latches the first divergence (cycle and lane).
- After divergence, tracks per-side commit of the end-of-test marker instruction and raises finished or timeout.
- Sits in the testbench beside both harnesses, fed by ports instead of hierarchical probes; replaces the single-lane, unbounded sync monitor.

Parameters:
- LANES, 2, enqueue/commit lanes compared per cycle (1..8).
- INST_W, 32, instruction width per lane.
- DONE_INST, 32'h00302013, end-of-test marker instruction.
- TIMEOUT, 4096, cycles allowed after divergence for both sides to reach DONE_INST; 0 disables the timeout.
- CNT_W, 32, width of the cycle counter and timeout counter.

Ports:
- clock  in  1  sampling clock, rising edge.
- reset  in  1  synchronous, active-low.
- dut_enq_valid  in  LANES  DUT per-lane enqueue valid.
- dut_enq_inst  in  LANES*INST_W  DUT per-lane enqueued instruction; lane i at [i*INST_W +: INST_W].
- vnt_enq_valid  in  LANES  variant per-lane enqueue valid.
- vnt_enq_inst  in  LANES*INST_W  variant per-lane enqueued instruction.
- dut_deq_valid  in  LANES  DUT per-lane commit valid.
- dut_deq_inst  in  LANES*INST_W  DUT committed instructions.
- vnt_deq_valid  in  LANES  variant per-lane commit valid.
- vnt_deq_inst  in  LANES*INST_W  variant committed instructions.
- in_sync  out  1  high while no divergence has been seen.
- div_cycle  out  CNT_W  cycle count at first divergence.
- div_lane  out  max(1,$clog2(LANES))  lowest mismatching lane at first divergence.
- dut_done  out  1  DUT committed DONE_INST after divergence.
- vnt_done  out  1  variant committed DONE_INST after divergence.
- finished  out  1  both sides done.
- timed_out  out  1  timeout expired before both sides were done.
- state  out  3  FSM state encoding, for debug.

Behaviour:
- Reset (reset==0 at posedge):
  - state=SYNC, in_sync=1.
  - div_cycle=0, div_lane=0.
  - dut_done=vnt_done=finished=timed_out=0.
  - cycle counter=0, timeout counter=0.
- Cycle counter: increments every non-reset cycle and saturates at all-ones.
- Lane mismatch (combinational):
  - dut_enq_valid[i] != vnt_enq_valid[i], OR
  - both valid and the instructions differ.
  - Instruction fields on lanes where both valid bits are low are ignored.
- FSM states, encoded 0..4:
  - SYNC(0): on any lane mismatch, go to DIVERGED next cycle. Latch div_cycle = current counter value and div_lane = lowest mismatching index. in_sync drops the cycle after the mismatch sample (1-cycle latency).
  - DIVERGED(1): done tracking is active. Once exactly one of dut_done/vnt_done is set, go to WAIT_OTHER. Once both are set, go to FINISHED.
  - WAIT_OTHER(2): once the remaining done flag is set, go to FINISHED.
  - FINISHED(3): terminal; finished=1; all outputs held until reset.
  - TIMEOUT(4): terminal; timed_out=1; all outputs held until reset.
- Done detection:
  - Qualified on registered state in {DIVERGED, WAIT_OTHER}.
  - dut_done sets when any lane has dut_deq_valid[i] with dut_deq_inst lane i == DONE_INST; vnt_done likewise.
  - Done flags are sticky.
  - Commits in the same cycle as the divergence sample (state still SYNC) are ignored.
  - Done flags visible 1 cycle after the commit; finished visible 1 cycle after the flag that completes the pair.
  - Both sides committing DONE_INST in the same cycle: both flags set together; DIVERGED→FINISHED with no WAIT_OTHER visit.
- Divergence latch: further mismatches after leaving SYNC never alter div_cycle or div_lane.
- Timeout (TIMEOUT>0):
  - Counter clears on entering DIVERGED.
  - Increments each cycle in DIVERGED/WAIT_OTHER.
  - When it equals TIMEOUT-1 and the FSM is not moving to FINISHED this cycle, go to TIMEOUT.
  - Completion and expiry in the same cycle: FINISHED wins.
- Mid-operation reset: any state returns to SYNC with all outputs cleared the following cycle; pending inputs that cycle are ignored.
- Monitor never stalls or backpressures inputs; pure observer.

Test Plan:
- Identical streams on both lanes for 1000 cycles, including DONE_INST commits -> in_sync=1, dut_done=0, finished=0 throughout (done ignored while in sync).
- Lane 1 inst differs (32'h00000013 vs 32'h00100013) at counter 57 -> next cycle in_sync=0, state=1, div_cycle=57, div_lane=1; a later lane-0 mismatch leaves div_lane=1.
- After divergence: DUT commits 32'h00302013 on lane 0 at +10, variant on lane 1 at +25 -> dut_done at +11, state=2, vnt_done at +26, finished and state=3 at +27.
- TIMEOUT=16: divergence, only DUT done -> timed_out=1, state=4 exactly 16 cycles after entering DIVERGED; vnt_done stays 0.
- Valid-only mismatch (dut_enq_valid=2'b01, vnt=2'b00) plus same-cycle DONE_INST commits -> divergence latched with div_lane=0; dut_done stays 0.
- reset driven low for 1 cycle while in WAIT_OTHER -> next cycle state=0, in_sync=1, all flags and div_* cleared.
